key_counter: RTL
================

KEY_COUNTER -- requirements
Module: key_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 12, giving the number of key inputs counted (legal range 1..63).
REQ-002 The module SHALL have parameter CNT_W, default 6, giving the count width; CNT_W SHALL satisfy 2^CNT_W > WIDTH, and CNT_W is not derived with $clog2.
REQ-003 The module SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive equal counts needed for stable (legal range 1..255).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port keys, input, WIDTH bits: key-pressed vector, 1 = pressed.
REQ-007 The module SHALL have port in_valid, input, 1 bit: keys is sampled this cycle.
REQ-008 The module SHALL have port clear_peak, input, 1 bit: synchronous clear of peak.
REQ-009 The module SHALL have port count, output, CNT_W bits: number of set bits in the last sampled keys.
REQ-010 The module SHALL have port count_valid, output, 1 bit: one-cycle pulse marking a new count.
REQ-011 The module SHALL have port changed, output, 1 bit: one-cycle pulse, the new count differs from the previous count.
REQ-012 The module SHALL have port stable, output, 1 bit: the count has held the same value for STABLE_CYCLES consecutive samples.
REQ-013 The module SHALL have port peak, output, CNT_W bits: maximum count since reset or the last clear_peak.
REQ-014 The module SHALL have port any_key, output, 1 bit: registered, count != 0.

Function
REQ-015 Stage 1 SHALL register keys into a sample register, and in_valid into a stage-1 valid, on every edge where in_valid=1; the stage-1 valid SHALL be 0 otherwise.
REQ-016 Stage 2 SHALL register the popcount of the sample register into count whenever the stage-1 valid=1, and count SHALL hold its value otherwise.
REQ-017 The popcount SHALL be the sum of all WIDTH bits at CNT_W width with no truncation.
REQ-018 The latency SHALL be 2: in_valid high at edge N SHALL produce count and count_valid=1 after edge N+1.
REQ-019 count_valid SHALL be 1 for exactly one cycle per accepted sample, so back-to-back in_valid yields back-to-back count_valid.
REQ-020 changed SHALL pulse with count_valid when the new count differs from the previously held count.
REQ-021 changed SHALL be 0 for the first sample after reset when that sample equals 0.
REQ-022 A run counter SHALL reset to 1 on a changed sample and SHALL increment on a non-changed sample, saturating at STABLE_CYCLES.
REQ-023 stable SHALL be 1 exactly when the run counter equals STABLE_CYCLES.
REQ-024 stable and the run counter SHALL update only on count_valid cycles and SHALL hold otherwise.
REQ-025 peak SHALL load the new count whenever count_valid=1 and the new count exceeds peak.
REQ-026 clear_peak=1 SHALL set peak to 0 on the next edge.
REQ-027 If clear_peak=1 and count_valid=1 fall on the same cycle, peak SHALL load the new count rather than 0.
REQ-028 any_key SHALL update together with count.
REQ-029 With WIDTH keys all set, count SHALL be WIDTH; with all keys clear, count SHALL be 0.
REQ-030 A keys change without in_valid SHALL have no effect on any output.

Reset
REQ-031 While resetn=0, the module SHALL clear count, peak, the sample register, the stage-1 valid and the run counter to 0.
REQ-032 While resetn=0, count_valid, changed, stable and any_key SHALL be 0.
REQ-033 Reset SHALL take effect immediately, without waiting for clk.
REQ-034 Reset mid-pipeline SHALL discard any in-flight sample, so no count_valid pulse is produced for it.
REQ-035 After resetn deasserts, the first in_valid SHALL be accepted on the first rising edge of clk.

Verification
REQ-036 The bench SHALL cover this scenario: WIDTH=12, keys=12'h0F3 with in_valid for 1 cycle -> 2 cycles later count=6, count_valid=1 for 1 cycle, changed=1, any_key=1, peak=6.
REQ-037 The bench SHALL cover this scenario: keys=12'hFFF then 12'h000 back-to-back -> count 12 then 0 on consecutive cycles, changed pulses both cycles, peak=12.
REQ-038 The bench SHALL cover this scenario: 5 consecutive samples of keys=12'h005, STABLE_CYCLES=4 -> stable=1 from the 4th count_valid onward; a 6th sample of 12'h007 -> changed=1 and stable=0.
REQ-039 The bench SHALL cover this scenario: peak=9 with clear_peak pulsed alone -> peak=0; clear_peak coincident with a count_valid of 3 -> peak=3.
REQ-040 The bench SHALL cover this scenario: resetn dropped 1 cycle after in_valid -> all outputs 0 immediately and no count_valid after release.
REQ-041 The bench SHALL cover this scenario: WIDTH=40, CNT_W=6, random keys over 1000 samples -> count equals a reference popcount and peak equals the running maximum.

Source files
------------

// File: rtl/key_counter.sv
// rtl/key_counter.sv - two-stage registered popcount of a key vector
// with change, stability and peak tracking on each new count.
module key_counter #(
  parameter int WIDTH         = 12,
  parameter int CNT_W         = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] keys,
  input  logic             in_valid,
  input  logic             clear_peak,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             changed,
  output logic             stable,
  output logic [CNT_W-1:0] peak,
  output logic             any_key
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

  logic [WIDTH-1:0] sample_q;
  logic             s1_valid_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] peak_q;
  logic [CNT_W-1:0] peak_d;
  logic [CNT_W-1:0] pop_d;
  logic [7:0]       run_q;
  logic [7:0]       run_d;
  logic             count_valid_q;
  logic             changed_q;
  logic             stable_q;
  logic             any_key_q;
  logic             is_change;

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + CNT_W'(sample_q[i]);
    end
  end

  // Comparing against the held count makes a first all-zero sample after reset a non-change.
  assign is_change = (pop_d != count_q);

  always_comb begin
    run_d = run_q;
    if (s1_valid_q) begin
      if (is_change) begin
        run_d = 8'd1;
      end else if (run_q < RUN_MAX) begin
        run_d = run_q + 8'd1;
      end
    end
  end

  // A new count arriving together with clear_peak wins over the clear.
  always_comb begin
    peak_d = peak_q;
    if (s1_valid_q && (clear_peak || (pop_d > peak_q))) begin
      peak_d = pop_d;
    end else if (clear_peak) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_q      <= '0;
      s1_valid_q    <= 1'b0;
      count_q       <= '0;
      peak_q        <= '0;
      run_q         <= '0;
      count_valid_q <= 1'b0;
      changed_q     <= 1'b0;
      stable_q      <= 1'b0;
      any_key_q     <= 1'b0;
    end else begin
      if (in_valid) begin
        sample_q <= keys;
      end
      s1_valid_q    <= in_valid;
      count_valid_q <= s1_valid_q;
      changed_q     <= s1_valid_q && is_change;
      peak_q        <= peak_d;
      run_q         <= run_d;
      if (s1_valid_q) begin
        count_q   <= pop_d;
        any_key_q <= (pop_d != '0);
        stable_q  <= (run_d == RUN_MAX);
      end
    end
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign changed     = changed_q;
  assign stable      = stable_q;
  assign peak        = peak_q;
  assign any_key     = any_key_q;

endmodule
